// File: rtl/hjdebug_pkg.sv
// hjdebug_pkg
// Shared definitions for the hjdebug host bridge: command and status byte
// codes, the bridge state enumeration and the register bus widths.
package hjdebug_pkg;

    localparam int AW = 12;
    localparam int DW = 32;

    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_REGERR  = 8'h01;
    localparam logic [7:0] ST_BADCMD  = 8'h02;
    localparam logic [7:0] ST_TIMEOUT = 8'h03;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDRL = 3'd1,
        ADDRH = 3'd2,
        WDAT  = 3'd3,
        REQ   = 3'd4,
        WAIT  = 3'd5,
        RESP  = 3'd6
    } state_t;

endpackage

// File: rtl/hjdebug_uartbridge.sv
// hjdebug_uartbridge
// Turns a UART byte stream into single hjdebug register transactions and
// returns a status byte (plus 4 little-endian data bytes on a good read).
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   rxdata/rxvalid/rxready   incoming command bytes
//   txdata/txvalid/txready   outgoing response bytes (registered, held until taken)
//   regreq/regwr/regaddr/regwdata   register bus request (regreq is a 1-cycle pulse)
//   regack/regerr/regrdata          register bus completion
//
// state | meaning
// IDLE  | waiting for command byte
// ADDRL | waiting for address low byte
// ADDRH | waiting for address high byte (low nibble used)
// WDAT  | collecting 4 write-data bytes, lane 0 first
// REQ   | regreq pulse, timeout counter cleared
// WAIT  | waiting for regack or timeout
// RESP  | sending status byte and optional read data
module hjdebug_uartbridge
    import hjdebug_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rxdata,
    input  logic          rxvalid,
    output logic          rxready,
    output logic [7:0]    txdata,
    output logic          txvalid,
    input  logic          txready,
    output logic          regreq,
    output logic          regwr,
    output logic [AW-1:0] regaddr,
    output logic [DW-1:0] regwdata,
    input  logic          regack,
    input  logic          regerr,
    input  logic [DW-1:0] regrdata
);

    state_t          state_q, state_d;
    logic            rst_done_q;
    logic            regreq_q, regreq_d;
    logic            regwr_q, regwr_d;
    logic [AW-1:0]   regaddr_q, regaddr_d;
    logic [DW-1:0]   regwdata_q, regwdata_d;
    logic [1:0]      wcnt_q, wcnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [7:0]      status_q, status_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [2:0]      txcnt_q, txcnt_d;
    logic            txvalid_q, txvalid_d;
    logic [7:0]      txdata_q, txdata_d;

    logic            rx_fire;
    logic            tx_fire;
    logic [2:0]      tx_last;

    // rxready is held low for the first cycle after reset release.
    assign rxready = rst_done_q &&
                     (state_q == IDLE || state_q == ADDRL ||
                      state_q == ADDRH || state_q == WDAT);
    assign rx_fire = rxvalid && rxready;
    assign tx_fire = txvalid_q && txready;

    // Only a successful read carries data bytes; index of the final byte.
    assign tx_last = (!regwr_q && status_q == ST_OK) ? 3'd4 : 3'd0;

    assign regreq   = regreq_q;
    assign regwr    = regwr_q;
    assign regaddr  = regaddr_q;
    assign regwdata = regwdata_q;
    assign txvalid  = txvalid_q;
    assign txdata   = txdata_q;

    always_comb begin
        state_d    = state_q;
        regreq_d   = 1'b0;
        regwr_d    = regwr_q;
        regaddr_d  = regaddr_q;
        regwdata_d = regwdata_q;
        wcnt_d     = wcnt_q;
        tmo_d      = tmo_q;
        status_d   = status_q;
        rdata_d    = rdata_q;
        txcnt_d    = txcnt_q;
        txvalid_d  = txvalid_q;
        txdata_d   = txdata_q;

        case (state_q)
            IDLE: begin
                if (rx_fire) begin
                    if (rxdata == CMD_READ) begin
                        regwr_d = 1'b0;
                        state_d = ADDRL;
                    end else if (rxdata == CMD_WRITE) begin
                        regwr_d = 1'b1;
                        state_d = ADDRL;
                    end else begin
                        status_d  = ST_BADCMD;
                        txdata_d  = ST_BADCMD;
                        txvalid_d = 1'b1;
                        txcnt_d   = 3'd0;
                        state_d   = RESP;
                    end
                end
            end
            ADDRL: begin
                if (rx_fire) begin
                    regaddr_d[7:0] = rxdata;
                    state_d        = ADDRH;
                end
            end
            ADDRH: begin
                if (rx_fire) begin
                    regaddr_d[11:8] = rxdata[3:0];
                    if (regwr_q) begin
                        wcnt_d  = 2'd0;
                        state_d = WDAT;
                    end else begin
                        regreq_d = 1'b1;
                        state_d  = REQ;
                    end
                end
            end
            WDAT: begin
                if (rx_fire) begin
                    regwdata_d[8*wcnt_q +: 8] = rxdata;
                    if (wcnt_q == 2'd3) begin
                        regreq_d = 1'b1;
                        state_d  = REQ;
                    end else begin
                        wcnt_d = wcnt_q + 2'd1;
                    end
                end
            end
            REQ: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // An ack on the expiry cycle takes priority over the timeout.
                if (regack) begin
                    status_d  = regerr ? ST_REGERR : ST_OK;
                    txdata_d  = regerr ? ST_REGERR : ST_OK;
                    rdata_d   = regrdata;
                    txvalid_d = 1'b1;
                    txcnt_d   = 3'd0;
                    state_d   = RESP;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    status_d  = ST_TIMEOUT;
                    txdata_d  = ST_TIMEOUT;
                    txvalid_d = 1'b1;
                    txcnt_d   = 3'd0;
                    state_d   = RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            RESP: begin
                if (tx_fire) begin
                    if (txcnt_q == tx_last) begin
                        txvalid_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        // Byte k+1 of the response is read data lane k.
                        txdata_d = rdata_q[8*txcnt_q[1:0] +: 8];
                        txcnt_d  = txcnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rst_done_q <= 1'b0;
            regreq_q   <= 1'b0;
            regwr_q    <= 1'b0;
            regaddr_q  <= '0;
            regwdata_q <= '0;
            wcnt_q     <= '0;
            tmo_q      <= '0;
            status_q   <= '0;
            rdata_q    <= '0;
            txcnt_q    <= '0;
            txvalid_q  <= 1'b0;
            txdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            rst_done_q <= 1'b1;
            regreq_q   <= regreq_d;
            regwr_q    <= regwr_d;
            regaddr_q  <= regaddr_d;
            regwdata_q <= regwdata_d;
            wcnt_q     <= wcnt_d;
            tmo_q      <= tmo_d;
            status_q   <= status_d;
            rdata_q    <= rdata_d;
            txcnt_q    <= txcnt_d;
            txvalid_q  <= txvalid_d;
            txdata_q   <= txdata_d;
        end
    end

endmodule

// File: tb/tb_hjdebug_uartbridge.sv
// tb_hjdebug_uartbridge
// Scoreboard bench for hjdebug_uartbridge: stimulus pushes expected bus
// transactions and response bytes into queues, monitors pop and compare.
module tb_hjdebug_uartbridge;
    import hjdebug_pkg::*;

    localparam int TIMEOUT = 16;
    localparam int TW      = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rxdata;
    logic          rxvalid;
    logic          rxready;
    logic [7:0]    txdata;
    logic          txvalid;
    logic          txready;
    logic          regreq;
    logic          regwr;
    logic [AW-1:0] regaddr;
    logic [DW-1:0] regwdata;
    logic          regack;
    logic          regerr;
    logic [DW-1:0] regrdata;

    always #5 clk = ~clk;

    hjdebug_uartbridge #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk(clk), .rst(rst),
        .rxdata(rxdata), .rxvalid(rxvalid), .rxready(rxready),
        .txdata(txdata), .txvalid(txvalid), .txready(txready),
        .regreq(regreq), .regwr(regwr), .regaddr(regaddr), .regwdata(regwdata),
        .regack(regack), .regerr(regerr), .regrdata(regrdata)
    );

    typedef logic [7:0] bq_t[$];
    typedef struct {logic wr; logic [11:0] addr; logic [31:0] wdata;} bus_t;
    typedef struct {int delay; logic err; logic [31:0] rdata; logic noack;} slv_t;

    bus_t       bus_q[$];
    logic [7:0] tx_q[$];
    slv_t       slv_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    int req_cyc = 0;
    int lat_expect = -1;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Register bus monitor
    bus_t mon_e;
    always @(negedge clk) begin
        if (!rst && regreq) begin
            if (bus_q.size() == 0) begin
                fail_now("unexpected_regreq");
            end else begin
                mon_e = bus_q.pop_front();
                check("regwr", 64'(regwr), 64'(mon_e.wr));
                check("regaddr", 64'(regaddr), 64'(mon_e.addr));
                if (mon_e.wr) check("regwdata", 64'(regwdata), 64'(mon_e.wdata));
                check("req_latency", 64'(cyc - last_acc_cyc), 64'd1);
            end
            req_cyc = cyc;
        end
    end

    // Slave model: one queued response per regreq
    slv_t slv_e;
    initial begin
        regack = 1'b0;
        regerr = 1'b0;
        regrdata = '0;
        forever begin
            @(negedge clk);
            if (!rst && regreq && slv_q.size() != 0) begin
                slv_e = slv_q.pop_front();
                if (!slv_e.noack) begin
                    repeat (slv_e.delay) @(posedge clk);
                    #1;
                    regack = 1'b1;
                    regerr = slv_e.err;
                    regrdata = slv_e.rdata;
                    @(posedge clk);
                    #1;
                    regack = 1'b0;
                    regerr = 1'b0;
                    regrdata = '0;
                end
            end
        end
    end

    // Transmit monitor
    logic       hold_v = 1'b0;
    logic [7:0] hold_d = '0;
    logic       txv_prev = 1'b0;
    logic [7:0] mon_b;
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
            txv_prev = 1'b0;
        end else begin
            if (hold_v) begin
                check("tx_hold_valid", 64'(txvalid), 64'd1);
                check("tx_hold_data", 64'(txdata), 64'(hold_d));
            end
            if (txvalid && !txv_prev && lat_expect >= 0) begin
                check("timeout_latency", 64'(cyc - req_cyc), 64'(lat_expect));
                lat_expect = -1;
            end
            if (txvalid && txready) begin
                if (tx_q.size() == 0) begin
                    fail_now("unexpected_tx_byte");
                end else begin
                    mon_b = tx_q.pop_front();
                    check("txdata", 64'(txdata), 64'(mon_b));
                end
            end
            hold_v = txvalid && !txready;
            hold_d = txdata;
            txv_prev = txvalid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bit acc = 1'b0;
        rxdata = b;
        rxvalid = 1'b1;
        while (!acc && n < 2000) begin
            @(negedge clk);
            if (rxready) begin
                acc = 1'b1;
                last_acc_cyc = cyc;
            end
            tick();
            n++;
        end
        rxvalid = 1'b0;
        if (!acc) fail_now("rx_accept_timeout");
    endtask

    task automatic send_frame(input bq_t f);
        foreach (f[i]) send_byte(f[i]);
    endtask

    task automatic exp_tx(input bq_t f);
        foreach (f[i]) tx_q.push_back(f[i]);
    endtask

    task automatic exp_bus(input logic wr, input logic [11:0] addr, input logic [31:0] wdata);
        bus_t e;
        e.wr = wr;
        e.addr = addr;
        e.wdata = wdata;
        bus_q.push_back(e);
    endtask

    task automatic exp_slv(input int delay, input logic err, input logic [31:0] rdata, input logic noack);
        slv_t e;
        e.delay = delay;
        e.err = err;
        e.rdata = rdata;
        e.noack = noack;
        slv_q.push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((tx_q.size() != 0 || bus_q.size() != 0 || txvalid) && n < 5000) begin
            tick();
            n++;
        end
        if (n >= 5000) fail_now("drain_timeout");
        tick();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_regreq"}, 64'(regreq), 64'd0);
        check({tag, "_txvalid"}, 64'(txvalid), 64'd0);
        check({tag, "_txdata"}, 64'(txdata), 64'd0);
        check({tag, "_rxready"}, 64'(rxready), 64'd0);
        check({tag, "_state"}, 64'(dut.state_q), 64'(IDLE));
        check({tag, "_regwr"}, 64'(regwr), 64'd0);
        check({tag, "_regaddr"}, 64'(regaddr), 64'd0);
        check({tag, "_regwdata"}, 64'(regwdata), 64'd0);
    endtask

    task automatic release_reset();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rxready_first_cycle", 64'(rxready), 64'd0);
        @(negedge clk);
        check("rxready_idle", 64'(rxready), 64'd1);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL global_watchdog (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        rxdata = '0;
        rxvalid = 1'b0;
        txready = 1'b1;
        repeat (3) tick();
        check_reset_state("reset");
        release_reset();

        // Write 0x00C = 0xDEADBEEF, ack after 3 cycles
        exp_bus(1'b1, 12'h00C, 32'hDEADBEEF);
        exp_slv(3, 1'b0, 32'h0, 1'b0);
        exp_tx('{8'h00});
        send_frame('{8'h02, 8'h0C, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
        wait_drain();

        // Read 0x008 with a 5-cycle txready stall after two bytes
        exp_bus(1'b0, 12'h008, 32'h0);
        exp_slv(2, 1'b0, 32'h12345678, 1'b0);
        exp_tx('{8'h00, 8'h78, 8'h56, 8'h34, 8'h12});
        txready = 1'b0;
        send_frame('{8'h01, 8'h08, 8'h00});
        n = 0;
        while (n < 2000) begin
            @(negedge clk);
            if (txvalid) break;
            n++;
        end
        if (n >= 2000) fail_now("txvalid_wait_timeout");
        tick();
        txready = 1'b1;
        tick();
        tick();
        txready = 1'b0;
        repeat (5) tick();
        txready = 1'b1;
        wait_drain();

        // Read with slave error: status byte only
        exp_bus(1'b0, 12'h010, 32'h0);
        exp_slv(1, 1'b1, 32'hFFFFFFFF, 1'b0);
        exp_tx('{8'h01});
        send_frame('{8'h01, 8'h10, 8'h00});
        wait_drain();

        // Bad command, then address high nibble masking
        exp_tx('{8'h02});
        send_frame('{8'h7F});
        wait_drain();
        exp_bus(1'b0, 12'h3FF, 32'h0);
        exp_slv(1, 1'b0, 32'hCAFE0001, 1'b0);
        exp_tx('{8'h00, 8'h01, 8'h00, 8'hFE, 8'hCA});
        send_frame('{8'h01, 8'hFF, 8'hF3});
        wait_drain();

        // Timeout: response one cycle after the TIMEOUT-th wait cycle;
        // the late ack arrives after the bridge is back in IDLE
        exp_bus(1'b0, 12'h004, 32'h0);
        exp_slv(TIMEOUT + 4, 1'b0, 32'h55555555, 1'b0);
        exp_tx('{8'h03});
        lat_expect = TIMEOUT + 1;
        send_frame('{8'h01, 8'h04, 8'h00});
        wait_drain();
        repeat (TIMEOUT + 10) tick();
        check("stray_ack_state", 64'(dut.state_q), 64'(IDLE));
        check("stray_ack_txvalid", 64'(txvalid), 64'd0);

        // Ack on the expiry cycle wins
        exp_bus(1'b0, 12'h020, 32'h0);
        exp_slv(TIMEOUT, 1'b0, 32'h0BADF00D, 1'b0);
        exp_tx('{8'h00, 8'h0D, 8'hF0, 8'hAD, 8'h0B});
        send_frame('{8'h01, 8'h20, 8'h00});
        wait_drain();

        // Reset after two write data bytes
        send_frame('{8'h02, 8'h0C, 8'h00, 8'h11, 8'h22});
        check("pre_reset_state_wdat", 64'(dut.state_q), 64'(WDAT));
        rst = 1'b1;
        #1;
        check_reset_state("rst_wdat");
        release_reset();

        // Reset while waiting for a slave that never answers
        exp_bus(1'b0, 12'h040, 32'h0);
        exp_slv(0, 1'b0, 32'h0, 1'b1);
        send_frame('{8'h01, 8'h40, 8'h00});
        repeat (4) tick();
        check("pre_reset_state_wait", 64'(dut.state_q), 64'(WAIT));
        rst = 1'b1;
        #1;
        check_reset_state("rst_wait");
        release_reset();

        // Fresh write after reset
        exp_bus(1'b1, 12'h134, 32'h01020304);
        exp_slv(2, 1'b0, 32'h0, 1'b0);
        exp_tx('{8'h00});
        send_frame('{8'h02, 8'h34, 8'h01, 8'h04, 8'h03, 8'h02, 8'h01});
        wait_drain();

        // Back-to-back: arm, then poll address 0 until bit 2 is set
        exp_bus(1'b1, 12'h000, 32'h00000002);
        exp_slv(1, 1'b0, 32'h0, 1'b0);
        exp_tx('{8'h00});
        for (int i = 0; i < 3; i++) begin
            exp_bus(1'b0, 12'h000, 32'h0);
            exp_slv(1 + i, 1'b0, (i == 2) ? 32'h6 : 32'h2, 1'b0);
            exp_tx('{8'h00, (i == 2) ? 8'h06 : 8'h02, 8'h00, 8'h00, 8'h00});
        end
        send_frame('{8'h02, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00});
        for (int i = 0; i < 3; i++) send_frame('{8'h01, 8'h00, 8'h00});
        wait_drain();

        check("bus_q_empty", 64'(bus_q.size()), 64'd0);
        check("tx_q_empty", 64'(tx_q.size()), 64'd0);
        check("slv_q_empty", 64'(slv_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
